// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 frame-refresh driver: command bytes and top-FSM states.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_LINE1        = 8'h80;
  localparam logic [7:0] LCD_LINE2        = 8'hC0;

  // Init nibbles sit in the high half so single-nibble items share the byte path.
  localparam logic [7:0] LCD_INIT_NIB3    = 8'h30;
  localparam logic [7:0] LCD_INIT_NIB2    = 8'h20;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_INIT_N3A,
    ST_INIT_N3B,
    ST_INIT_N3C,
    ST_INIT_N2,
    ST_CMD_FUNC,
    ST_CMD_ENTRY,
    ST_CMD_DISP,
    ST_CMD_CLEAR,
    ST_REF_ADDR,
    ST_REF_DATA,
    ST_FRAME_END
  } lcd_state_t;

endpackage

// File: rtl/lcd_frame_refresh_if.sv
// 4-bit write-only HD44780 bus.
interface lcd_frame_refresh_if;
  logic lcd_rs;
  logic lcd_rw;
  logic lcd_e;
  logic lcd_4;
  logic lcd_5;
  logic lcd_6;
  logic lcd_7;

  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7);
  modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7);
endinterface

// File: rtl/lcd_frame_refresh_nibble_tx.sv
// Single-nibble strobe: drives RS/data, waits E_SETUP, holds E high for E_HIGH cycles.
module lcd_nibble_tx #(
  parameter int unsigned E_SETUP = 2,
  parameter int unsigned E_HIGH  = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam int unsigned CMAX = (E_SETUP > E_HIGH) ? E_SETUP : E_HIGH;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_HIGH} tx_state_t;

  tx_state_t      st, st_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           rs_n, e_n;
  logic [3:0]     d_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= TX_IDLE;
      cnt    <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_d  <= '0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      lcd_rs <= rs_n;
      lcd_e  <= e_n;
      lcd_d  <= d_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = (cnt != '0) ? cnt - 1'b1 : cnt;
    rs_n  = lcd_rs;
    e_n   = lcd_e;
    d_n   = lcd_d;
    case (st)
      TX_IDLE: if (start) begin
        rs_n  = rs;
        d_n   = nibble;
        cnt_n = CW'(E_SETUP - 1);
        st_n  = TX_SETUP;
      end
      TX_SETUP: if (cnt == '0) begin
        e_n   = 1'b1;
        cnt_n = CW'(E_HIGH - 1);
        st_n  = TX_HIGH;
      end
      TX_HIGH: if (cnt == '0) begin
        e_n  = 1'b0;
        st_n = TX_IDLE;
      end
      default: st_n = TX_IDLE;
    endcase
  end

  assign busy = (st != TX_IDLE);
  // High in the cycle whose closing edge drops E.
  assign done = (st == TX_HIGH) && (cnt == '0);

endmodule

// File: rtl/lcd_frame_refresh.sv
// HD44780 16x2 driver: power-on init once, then rewrites both lines from a per-pass snapshot.
module lcd_frame_refresh #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned E_SETUP = 2,
  parameter int unsigned E_HIGH  = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [255:0]               chars,
  lcd_frame_refresh_if.master        lcd,
  output logic                       init_done,
  output logic                       frame_done
);
  import lcd_pkg::*;

  localparam int unsigned DW = $clog2(T_PWRUP + 1);

  lcd_state_t    state, state_n, item, item_next;
  logic          hi_lo, hi_lo_n;
  logic [DW-1:0] delay, delay_n, item_wait;
  logic [4:0]    idx, idx_n, inv_idx;
  logic [255:0]  snap;
  logic          init_done_n, frame_done_n, snap_load;
  logic          item_rs, item_single;
  logic [7:0]    item_byte, char_sel;
  logic          tx_start, tx_rs, tx_busy, tx_done, bus_rs, bus_e;
  logic [3:0]    tx_nib, bus_d;

  lcd_nibble_tx #(
    .E_SETUP(E_SETUP),
    .E_HIGH (E_HIGH)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .rs     (tx_rs),
    .nibble (tx_nib),
    .busy   (tx_busy),
    .done   (tx_done),
    .lcd_rs (bus_rs),
    .lcd_e  (bus_e),
    .lcd_d  (bus_d)
  );

  assign lcd.lcd_rs = bus_rs;
  assign lcd.lcd_rw = 1'b0;
  assign lcd.lcd_e  = bus_e;
  assign {lcd.lcd_7, lcd.lcd_6, lcd.lcd_5, lcd.lcd_4} = bus_d;

  // chars[255:248] is index 0, so the byte offset is 31-idx, i.e. ~idx.
  assign inv_idx  = ~idx;
  assign char_sel = snap[{inv_idx, 3'b000} +: 8];

  // PWRUP issues the first init nibble directly, so it shares N3A's item entry.
  always_comb begin
    item        = (state == ST_PWRUP) ? ST_INIT_N3A : state;
    item_rs     = 1'b0;
    item_byte   = '0;
    item_single = 1'b0;
    item_wait   = DW'(T_CMD - 1);
    item_next   = item;
    case (item)
      ST_INIT_N3A:  begin item_byte = LCD_INIT_NIB3; item_single = 1'b1;
                          item_wait = DW'(T_INIT1 - 1); item_next = ST_INIT_N3B; end
      ST_INIT_N3B:  begin item_byte = LCD_INIT_NIB3; item_single = 1'b1;
                          item_wait = DW'(T_INIT2 - 1); item_next = ST_INIT_N3C; end
      ST_INIT_N3C:  begin item_byte = LCD_INIT_NIB3; item_single = 1'b1; item_next = ST_INIT_N2; end
      ST_INIT_N2:   begin item_byte = LCD_INIT_NIB2; item_single = 1'b1; item_next = ST_CMD_FUNC; end
      ST_CMD_FUNC:  begin item_byte = LCD_FUNC_4BIT_2L; item_next = ST_CMD_ENTRY; end
      ST_CMD_ENTRY: begin item_byte = LCD_ENTRY_INC;    item_next = ST_CMD_DISP;  end
      ST_CMD_DISP:  begin item_byte = LCD_DISP_ON;      item_next = ST_CMD_CLEAR; end
      ST_CMD_CLEAR: begin item_byte = LCD_CLEAR; item_wait = DW'(T_CLEAR - 1); item_next = ST_REF_ADDR; end
      ST_REF_ADDR:  begin item_byte = idx[4] ? LCD_LINE2 : LCD_LINE1; item_next = ST_REF_DATA; end
      ST_REF_DATA:  begin
        item_rs   = 1'b1;
        item_byte = char_sel;
        if (idx == 5'd31)      item_next = ST_FRAME_END;
        else if (idx == 5'd15) item_next = ST_REF_ADDR;
        else                   item_next = ST_REF_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state;
    hi_lo_n      = hi_lo;
    idx_n        = idx;
    init_done_n  = init_done;
    frame_done_n = 1'b0;
    delay_n      = (delay != '0) ? delay - 1'b1 : delay;
    tx_start     = 1'b0;
    snap_load    = 1'b0;
    tx_rs        = item_rs;
    tx_nib       = hi_lo ? item_byte[3:0] : item_byte[7:4];
    if (tx_busy) begin
      if (tx_done) begin
        if (!item_single && !hi_lo) begin
          hi_lo_n = 1'b1;
          delay_n = DW'(T_NIB - 1);
        end else begin
          hi_lo_n = 1'b0;
          delay_n = item_wait;
          state_n = item_next;
          if (state == ST_REF_DATA) idx_n = idx + 5'd1;
        end
      end
    end else if (delay == '0) begin
      if (state == ST_FRAME_END) begin
        frame_done_n = 1'b1;
        state_n      = ST_REF_ADDR;
      end else begin
        tx_start = 1'b1;
        state_n  = item;
        if (item == ST_REF_ADDR) begin
          init_done_n = 1'b1;
          snap_load   = (idx == '0) && !hi_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PWRUP;
      hi_lo      <= 1'b0;
      delay      <= DW'(T_PWRUP - 1);
      idx        <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      hi_lo      <= hi_lo_n;
      delay      <= delay_n;
      idx        <= idx_n;
      init_done  <= init_done_n;
      frame_done <= frame_done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         snap <= '0;
    else if (snap_load) snap <= chars;
  end

endmodule

// File: tb/tb_lcd_frame_refresh.sv
// Scoreboard bench for lcd_frame_refresh: expected nibble stream with timing is queued, bus monitor pops and compares.
module tb_lcd_frame_refresh;

  localparam int unsigned T_PWRUP  = 300;
  localparam int unsigned T_INIT1  = 120;
  localparam int unsigned T_INIT2  = 40;
  localparam int unsigned T_CMD    = 20;
  localparam int unsigned T_CLEAR  = 90;
  localparam int unsigned T_NIB    = 5;
  localparam int unsigned E_SETUP  = 2;
  localparam int unsigned E_HIGH   = 12;
  localparam int unsigned WAIT_MAX = 10000;

  typedef struct {
    logic        rs;
    logic [3:0]  nib;
    int unsigned gap;
    logic        ini;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] chars = '0;
  logic         init_done, frame_done;

  lcd_frame_refresh_if lcd ();

  lcd_frame_refresh #(
    .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
    .T_CLEAR(T_CLEAR), .T_NIB(T_NIB), .E_SETUP(E_SETUP), .E_HIGH(E_HIGH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chars      (chars),
    .lcd        (lcd),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  exp_t        exp_q[$];

  int unsigned frames = 0;
  int unsigned rises_rst = 0;
  int unsigned pass_nibs = 0;
  int unsigned run = 0;
  int unsigned stable = 0;
  logic        prev_e = 1'b0;
  logic        prev_fd = 1'b0;
  logic        first_frame = 1'b1;
  logic [4:0]  prev_bus = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] nib, input int unsigned wait_cyc, input logic ini);
    exp_t e;
    e.rs  = rs;
    e.nib = nib;
    e.gap = wait_cyc + E_SETUP;
    e.ini = ini;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input int unsigned wait_cyc, input logic ini);
    push_nib(rs, b[7:4], wait_cyc, ini);
    push_nib(rs, b[3:0], T_NIB, ini);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3, T_PWRUP, 1'b0);
    push_nib(1'b0, 4'h3, T_INIT1, 1'b0);
    push_nib(1'b0, 4'h3, T_INIT2, 1'b0);
    push_nib(1'b0, 4'h2, T_CMD,   1'b0);
    push_byte(1'b0, 8'h28, T_CMD, 1'b0);
    push_byte(1'b0, 8'h06, T_CMD, 1'b0);
    push_byte(1'b0, 8'h0C, T_CMD, 1'b0);
    push_byte(1'b0, 8'h01, T_CMD, 1'b0);
  endtask

  // A pass right after init follows the clear wait; later passes follow T_CMD plus the frame_done cycle.
  task automatic push_pass(input logic [255:0] f, input logic after_init);
    push_byte(1'b0, 8'h80, after_init ? T_CLEAR : T_CMD + 1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) push_byte(1'b0, 8'hC0, T_CMD, 1'b1);
      push_byte(1'b1, f[255 - 8*i -: 8], T_CMD, 1'b1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_e"},  lcd.lcd_e, 0);
    check_val({tag, "_rs"}, lcd.lcd_rs, 0);
    check_val({tag, "_rw"}, lcd.lcd_rw, 0);
    check_val({tag, "_d"},  {lcd.lcd_7, lcd.lcd_6, lcd.lcd_5, lcd.lcd_4}, 0);
    check_val({tag, "_init_done"},  init_done, 0);
    check_val({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Bus monitor: run counts cycles since the last E edge (or reset release).
  always @(negedge clk) begin
    logic [4:0] cur_bus;
    exp_t       e;
    if (!rst_n) begin
      run = 0; stable = 0; prev_e = 1'b0; prev_fd = 1'b0;
      prev_bus = '0; pass_nibs = 0; rises_rst = 0; first_frame = 1'b1;
    end else begin
      run++;
      cur_bus = {lcd.lcd_rs, lcd.lcd_7, lcd.lcd_6, lcd.lcd_5, lcd.lcd_4};
      if (cur_bus != prev_bus) stable = 0;
      else                     stable++;
      prev_bus = cur_bus;
      if (lcd.lcd_e && !prev_e) begin
        check_val("rw_low", lcd.lcd_rw, 0);
        check_val("setup_stable", stable >= E_SETUP, 1);
        check_val("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("nib_rs",    lcd.lcd_rs, e.rs);
          check_val("nib_data",  cur_bus[3:0], e.nib);
          check_val("nib_gap",   run, e.gap);
          check_val("init_done", init_done, e.ini);
        end
        pass_nibs++;
        rises_rst++;
        run = 0;
      end else if (!lcd.lcd_e && prev_e) begin
        check_val("e_high_len", run, E_HIGH);
        check_val("hold_stable", stable >= E_SETUP + E_HIGH, 1);
        run = 0;
      end
      prev_e = lcd.lcd_e;
      if (prev_fd) check_val("frame_done_width", frame_done, 0);
      if (frame_done && !prev_fd) begin
        check_val("frame_done_gap", run, T_CMD);
        check_val("frame_done_nibs", pass_nibs, first_frame ? 80 : 68);
        pass_nibs   = 0;
        first_frame = 1'b0;
        frames++;
      end
      prev_fd = frame_done;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got no summary, expected finish within 80000 cycles");
    $fatal(1);
  end

  initial begin
    logic [255:0] fa, fb;
    int unsigned  f0;
    fa = {"Hello World!!!!!!!! Value: 0x05", " "};
    for (int i = 0; i < 8; i++) fb[32*i +: 32] = $urandom;
    fb[255:248] = 8'h00;
    fb[127:120] = 8'h07;
    fb[7:0]     = 8'hFF;

    chars = fa;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    push_init();
    push_pass(fa, 1'b1);
    push_pass(fa, 1'b0);
    #1 rst_n = 1'b1;

    // Change content after the 5th data byte of pass 2; pass 2 must stay on fa.
    for (int n = 0; n < WAIT_MAX && !(frames == 1 && pass_nibs >= 12); n++) @(negedge clk);
    check_val("reach_pass2_byte5", (frames == 1 && pass_nibs >= 12), 1);
    chars = fb;
    push_pass(fb, 1'b0);
    push_pass(fb, 1'b0);

    // Reset while E is high in a data byte of pass 4.
    for (int n = 0; n < WAIT_MAX && !(frames == 3 && pass_nibs >= 7 && lcd.lcd_e); n++) @(negedge clk);
    check_val("reach_pass4_data", (frames == 3 && pass_nibs >= 7 && lcd.lcd_e), 1);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst_data");
    exp_q.delete();
    push_init();
    push_pass(fa, 1'b1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset during the wait that follows the clear command.
    for (int n = 0; n < WAIT_MAX && rises_rst < 12; n++) @(negedge clk);
    check_val("reach_clear", rises_rst, 12);
    repeat (E_HIGH + 4) @(negedge clk);
    check_val("init_done_clear_wait", init_done, 0);
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("rst_clear");
    exp_q.delete();
    push_init();
    push_pass(fb, 1'b1);
    push_pass(fb, 1'b0);
    f0 = frames;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < WAIT_MAX && frames < f0 + 2; n++) @(negedge clk);
    check_val("final_frames", frames - f0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
